fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   fetch_state_t : fetch FSM states (BOOT, RUN, HALT)
//   EBREAK_INSTR  : encoding of EBREAK; loading it halts fetch
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake and flush.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush_i        : drop the held entry (wins over load)
//   load_i         : capture pc_i/instr_i and mark valid
//   ready_i        : consumer accepts the held entry this cycle
//   pc_i, instr_i  : incoming fetch result
//   valid_o, pc_o, instr_o : held entry
module if_id_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] instr_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] instr_o
);

    logic             valid_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (flush_i) begin
            // pc/instr are left as-is; they are meaningless once valid drops
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, boot/run/halt FSM, and IF/ID register.
// Instruction memory is read asynchronously, so an address presented in one
// cycle lands in IF/ID at the next rising edge.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   imem_addr, imem_read_en   : word address / read enable to instruction memory
//   imem_instr                : asynchronous read data
//   redirect_valid/_pc        : branch/jump/trap redirect (highest priority)
//   if_valid/if_ready         : IF/ID handshake toward decode
//   if_pc, if_instr           : held instruction and its PC
//   halted                    : fetch stopped after EBREAK
//   fetch_count               : load counter, only when FETCH_PERF_CNT_EN is defined
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               ADDRESS_SIZE = 10,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    output logic                    imem_read_en,
    input  logic [WIDTH-1:0]        imem_instr,
    input  logic                    redirect_valid,
    input  logic [WIDTH-1:0]        redirect_pc,
    output logic                    if_valid,
    input  logic                    if_ready,
    output logic [WIDTH-1:0]        if_pc,
    output logic [WIDTH-1:0]        if_instr,
    output logic                    halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             fetch_count
`endif
);

    fetch_state_t     state_q;
    logic             halted_q;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             load;
    logic             is_ebreak;

    assign load      = (state_q == ST_RUN) && (!if_valid || if_ready) && !redirect_valid;
    assign is_ebreak = (imem_instr == WIDTH'(EBREAK_INSTR));

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc & ~WIDTH'(3);   // targets are word aligned
        else if (load)
            pc_d = pc_q + WIDTH'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                // a redirect overrides any EBREAK seen in the same cycle
                state_q  <= ST_RUN;
                halted_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_BOOT: state_q <= ST_RUN;
                    ST_RUN: if (load && is_ebreak) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_addr    = pc_q[ADDRESS_SIZE+1:2];
    assign imem_read_en = load;
    assign halted       = halted_q;

    if_id_reg #(.WIDTH(WIDTH)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .load_i  (load),
        .ready_i (if_ready),
        .pc_i    (pc_q),
        .instr_i (imem_instr),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .instr_o (if_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    always_ff @(posedge clk) begin
        if (rst)
            fetch_count_q <= '0;
        else if (load)
            fetch_count_q <= fetch_count_q + 32'd1;
    end
    assign fetch_count = fetch_count_q;
`endif

endmodule
